// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed refresh of a common-anode 7-segment bank.
// Written values wait in a shadow register and are promoted at frame end so a
// frame never mixes old and new digits.
module display_scan_ctrl #(
  parameter int unsigned N_DIG     = 4,
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [4*N_DIG-1:0] wr_data,
  input  logic               blank_lz,
  output logic [N_DIG-1:0]   an,
  output logic [6:0]         seg,
  output logic               pending,
  output logic               frame_done
);

  localparam int unsigned DATA_W  = 4 * N_DIG;
  localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = $clog2(N_DIG);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);
  localparam logic [6:0]       SEG_OFF    = 7'h7F;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [N_DIG-1:0]    an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                frame_done_q, frame_done_d;

  logic                frame_end;
  logic [N_DIG-1:0]    lz_run;
  logic                zero_run;
  logic [3:0]          nib;
  logic                dark;

  // Active-low hex to {g,f,e,d,c,b,a} decode.
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: slot timing, digit advance, shadow capture and frame-end promotion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    frame_end = 1'b0;

    if (wr_en) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end

    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase

    // Promotion uses the shadow before this edge; a same-edge write stays pending.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = wr_en;
    end

    frame_done_d = frame_end;
  end

  // Output decode from next-state values so registered an/seg align with state_q.
  always_comb begin
    zero_run = 1'b1;
    lz_run   = '0;
    nib      = 4'h0;
    dark     = 1'b0;
    an_d     = '1;
    seg_d    = SEG_OFF;

    for (int i = int'(N_DIG) - 1; i >= 0; i--) begin
      zero_run  = zero_run & (active_d[4*i +: 4] == 4'h0);
      lz_run[i] = zero_run;
    end

    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (IDX_W'(i) == idx_d) begin
        nib  = active_d[4*i +: 4];
        dark = blank_lz && (i != 0) && lz_run[i];
      end
    end

    if (state_d == S_SHOW && !dark) begin
      for (int unsigned i = 0; i < N_DIG; i++) begin
        an_d[i] = (IDX_W'(i) != idx_d);
      end
      seg_d = seg_decode(nib);
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (N_DIG=4, CLK_DIV=4, BLANK_CYC=2; 24-cycle frame).
module tb_display_scan_ctrl;

  localparam int unsigned N_DIG     = 4;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned FRAME     = N_DIG * (CLK_DIV + BLANK_CYC);
  localparam int unsigned SLOT      = CLK_DIV + BLANK_CYC;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_done;

  int checks;
  int failures;

  logic [3:0][3:0] cap_an;
  logic [3:0][6:0] cap_seg;
  bit              cap_stable;

  display_scan_ctrl #(
    .N_DIG    (N_DIG),
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .pending   (pending),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants: one anode at most, 24-cycle frame_done spacing, dark blank slots.
  int  cyc;
  int  last_fd;
  bit  last_fd_vld;
  int  phase;
  bit  phase_vld;
  initial begin
    cyc = 0; last_fd = 0; last_fd_vld = 0; phase = 0; phase_vld = 0;
  end
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      last_fd_vld = 0;
      phase_vld   = 0;
    end else begin
      checks++;
      if ($countones(~an) > 1) begin
        failures++;
        $display("FAIL inv_one_anode cyc=%0d an=%h", cyc, an);
      end
      if (frame_done) begin
        if (last_fd_vld) begin
          checks++;
          if (cyc - last_fd != int'(FRAME)) begin
            failures++;
            $display("FAIL inv_frame_spacing got=%0d want=%0d", cyc - last_fd, FRAME);
          end
        end
        last_fd     = cyc;
        last_fd_vld = 1;
        phase       = 0;
        phase_vld   = 1;
      end else if (phase_vld) begin
        phase++;
      end
      if (phase_vld && (phase % int'(SLOT)) < int'(BLANK_CYC)) begin
        checks++;
        if (an !== 4'hF) begin
          failures++;
          $display("FAIL inv_blank_dark cyc=%0d an=%h want=f", cyc, an);
        end
      end
    end
  end

  // Advance to the next frame_done cycle, bounded.
  task automatic wait_frame_done();
    bit seen;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL frame_done_timeout got=none want=pulse within 40 cycles");
    end
  endtask

  // One-cycle write strobe launched from the current negedge.
  task automatic do_write(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Records each digit slot of one frame; call on the frame_done cycle, returns at cycle 23.
  task automatic capture_frame();
    int d;
    int p;
    cap_stable = 1;
    for (int c = 0; c < int'(FRAME); c++) begin
      if (c > 0) @(negedge clk);
      d = c / int'(SLOT);
      p = c % int'(SLOT);
      if (p == int'(BLANK_CYC)) begin
        cap_an[d]  = an;
        cap_seg[d] = seg;
      end else if (p > int'(BLANK_CYC)) begin
        if (an !== cap_an[d] || seg !== cap_seg[d]) cap_stable = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (an !== 4'hF)      begin failures++; $display("FAIL reset_an got=%h want=f", an); end
    if (seg !== 7'h7F)    begin failures++; $display("FAIL reset_seg got=%h want=7f", seg); end
    if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b want=0", pending); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    #1 rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (an !== 4'hF)   begin failures++; $display("FAIL post_reset_blank_an got=%h want=f", an); end
    if (seg !== 7'h7F) begin failures++; $display("FAIL post_reset_blank_seg got=%h want=7f", seg); end
    @(negedge clk);
    checks += 2;
    if (an !== 4'hE)   begin failures++; $display("FAIL first_digit_an got=%h want=e", an); end
    if (seg !== 7'h40) begin failures++; $display("FAIL first_digit_seg got=%h want=40", seg); end
  endtask

  task automatic test_deferred_load();
    logic [3:0][3:0] ea;
    logic [3:0][6:0] es;
    ea = {4'h7, 4'hB, 4'hD, 4'hE};
    es = {7'h79, 7'h24, 7'h30, 7'h19};
    do_write(16'h1234);
    checks += 3;
    if (pending !== 1'b1) begin failures++; $display("FAIL defer_pending_set got=%b want=1", pending); end
    if (an !== 4'hE)      begin failures++; $display("FAIL defer_old_an got=%h want=e", an); end
    if (seg !== 7'h40)    begin failures++; $display("FAIL defer_old_seg0 got=%h want=40", seg); end
    repeat (5) @(negedge clk);
    checks += 2;
    if (an !== 4'hD)   begin failures++; $display("FAIL defer_old_an1 got=%h want=d", an); end
    if (seg !== 7'h40) begin failures++; $display("FAIL defer_old_seg1 got=%h want=40", seg); end
    wait_frame_done();
    checks++;
    if (pending !== 1'b0) begin failures++; $display("FAIL defer_pending_clear got=%b want=0", pending); end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks += 2;
      if (cap_an[d] !== ea[d])  begin failures++; $display("FAIL defer_an d%0d got=%h want=%h", d, cap_an[d], ea[d]); end
      if (cap_seg[d] !== es[d]) begin failures++; $display("FAIL defer_seg d%0d got=%h want=%h", d, cap_seg[d], es[d]); end
    end
    checks++;
    if (!cap_stable) begin failures++; $display("FAIL defer_slot_stable got=0 want=1"); end
  endtask

  task automatic test_last_write_wins();
    logic [3:0][3:0] ea;
    logic [3:0][6:0] es;
    ea = {4'h7, 4'hB, 4'hD, 4'hE};
    es = {7'h08, 7'h03, 7'h46, 7'h21};
    wait_frame_done();
    do_write(16'h1111);
    do_write(16'hABCD);
    wait_frame_done();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks += 2;
      if (cap_an[d] !== ea[d])  begin failures++; $display("FAIL lww_an d%0d got=%h want=%h", d, cap_an[d], ea[d]); end
      if (cap_seg[d] !== es[d]) begin failures++; $display("FAIL lww_seg d%0d got=%h want=%h", d, cap_seg[d], es[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][3:0] ea;
    logic [3:0][6:0] es1;
    logic [3:0][6:0] es2;
    ea  = {4'h7, 4'hB, 4'hD, 4'hE};
    es1 = {7'h12, 7'h02, 7'h78, 7'h00};
    es2 = {7'h10, 7'h10, 7'h10, 7'h10};
    wait_frame_done();
    do_write(16'h1234);
    wait_frame_done();
    do_write(16'h5678);
    repeat (22) @(negedge clk);
    checks += 2;
    if (an !== 4'h7)   begin failures++; $display("FAIL b2b_pre_an got=%h want=7", an); end
    if (seg !== 7'h79) begin failures++; $display("FAIL b2b_pre_seg got=%h want=79", seg); end
    wr_en   = 1'b1;
    wr_data = 16'h9999;
    @(negedge clk);
    wr_en   = 1'b0;
    checks += 2;
    if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_fd1 got=%b want=1", frame_done); end
    if (pending !== 1'b1)    begin failures++; $display("FAIL b2b_pending_held got=%b want=1", pending); end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks += 2;
      if (cap_an[d] !== ea[d])   begin failures++; $display("FAIL b2b_f1_an d%0d got=%h want=%h", d, cap_an[d], ea[d]); end
      if (cap_seg[d] !== es1[d]) begin failures++; $display("FAIL b2b_f1_seg d%0d got=%h want=%h", d, cap_seg[d], es1[d]); end
    end
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL b2b_pending_f1 got=%b want=1", pending); end
    @(negedge clk);
    checks += 2;
    if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_fd2 got=%b want=1", frame_done); end
    if (pending !== 1'b0)    begin failures++; $display("FAIL b2b_pending_drop got=%b want=0", pending); end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seg[d] !== es2[d]) begin failures++; $display("FAIL b2b_f2_seg d%0d got=%h want=%h", d, cap_seg[d], es2[d]); end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0][3:0] ea1;
    logic [3:0][6:0] es1;
    logic [3:0][3:0] ea2;
    logic [3:0][6:0] es2;
    ea1 = {4'hF, 4'hF, 4'hD, 4'hE};
    es1 = {7'h7F, 7'h7F, 7'h12, 7'h40};
    ea2 = {4'hF, 4'hF, 4'hF, 4'hE};
    es2 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    wait_frame_done();
    do_write(16'h0050);
    wait_frame_done();
    blank_lz = 1'b1;
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks += 2;
      if (cap_an[d] !== ea1[d])  begin failures++; $display("FAIL lz50_an d%0d got=%h want=%h", d, cap_an[d], ea1[d]); end
      if (cap_seg[d] !== es1[d]) begin failures++; $display("FAIL lz50_seg d%0d got=%h want=%h", d, cap_seg[d], es1[d]); end
    end
    wait_frame_done();
    do_write(16'h0000);
    wait_frame_done();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks += 2;
      if (cap_an[d] !== ea2[d])  begin failures++; $display("FAIL lz0_an d%0d got=%h want=%h", d, cap_an[d], ea2[d]); end
      if (cap_seg[d] !== es2[d]) begin failures++; $display("FAIL lz0_seg d%0d got=%h want=%h", d, cap_seg[d], es2[d]); end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_async_reset();
    wait_frame_done();
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'hE) begin failures++; $display("FAIL areset_pre_an got=%h want=e", an); end
    #2 rst = 1'b0;
    #1;
    checks += 2;
    if (an !== 4'hF)   begin failures++; $display("FAIL areset_an got=%h want=f", an); end
    if (seg !== 7'h7F) begin failures++; $display("FAIL areset_seg got=%h want=7f", seg); end
    @(negedge clk);
    #1 rst = 1'b1;
    wait_frame_done();
    wait_frame_done();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_en    = 1'b0;
    wr_data  = '0;
    blank_lz = 1'b0;
    test_reset();
    test_deferred_load();
    test_last_write_wins();
    test_back_to_back();
    test_leading_zero();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
